// File: rtl/arith_unit_if.sv
// Operation/result bundle for arith_unit: the execute stage drives the master side,
// the arithmetic unit implements the slave side.
interface arith_unit_if;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  opcode;
  logic [15:0] outau;
  logic        out_valid;
  logic        carry;
  logic        zero;
  logic        neg;
  logic        ovf;

  modport master (
    output en, a, b, opcode,
    input  outau, out_valid, carry, zero, neg, ovf
  );

  modport slave (
    input  en, a, b, opcode,
    output outau, out_valid, carry, zero, neg, ovf
  );
endinterface

// File: rtl/arith_unit.sv
// Registered 16-bit arithmetic unit with a stored chaining carry for ADC/SBB.
// Define ARITH_MUL_EN to build the 16x16 multiplier for opcode 100.
module arith_unit (
  input  logic         clk,
  input  logic         rst_n,
  arith_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpInc = 3'b010,
    OpDec = 3'b011,
    OpMul = 3'b100,
    OpNeg = 3'b101,
    OpAdc = 3'b110,
    OpSbb = 3'b111
  } op_e;

  logic [15:0] outau_q;
  logic        valid_q;
  logic        carry_q;
  logic        zero_q;
  logic        neg_q;
  logic        ovf_q;

  logic [15:0] res_d;
  logic        carry_d;
  logic        ovf_d;
  logic [16:0] wide;
  op_e         op;

`ifdef ARITH_MUL_EN
  logic [31:0] prod;
  assign prod = 32'(bus.a) * 32'(bus.b);
`endif

  assign op = op_e'(bus.opcode);

  // Same-sign operands producing a result of the other sign.
  function automatic logic add_ovf(logic x, logic y, logic r);
    return (x == y) && (r != x);
  endfunction

  // Differently signed operands where the result sign departs from the minuend.
  function automatic logic sub_ovf(logic x, logic y, logic r);
    return (x != y) && (r != x);
  endfunction

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    wide    = '0;
    unique case (op)
      OpAdd: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b};
        res_d   = wide[15:0];
        carry_d = wide[16];
        ovf_d   = add_ovf(bus.a[15], bus.b[15], wide[15]);
      end
      OpSub: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b};
        res_d   = wide[15:0];
        carry_d = wide[16];
        ovf_d   = sub_ovf(bus.a[15], bus.b[15], wide[15]);
      end
      OpInc: begin
        wide    = {1'b0, bus.a} + 17'd1;
        res_d   = wide[15:0];
        carry_d = wide[16];
        ovf_d   = add_ovf(bus.a[15], 1'b0, wide[15]);
      end
      OpDec: begin
        wide    = {1'b0, bus.a} - 17'd1;
        res_d   = wide[15:0];
        carry_d = wide[16];
        ovf_d   = sub_ovf(bus.a[15], 1'b0, wide[15]);
      end
      OpMul: begin
`ifdef ARITH_MUL_EN
        res_d   = prod[15:0];
        carry_d = |prod[31:16];
        ovf_d   = |prod[31:16];
`else
        // No multiplier: produce a zero result and clear the chaining carry.
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
`endif
      end
      OpNeg: begin
        wide    = 17'd0 - {1'b0, bus.a};
        res_d   = wide[15:0];
        carry_d = (bus.a != 16'h0000);
        ovf_d   = (bus.a == 16'h8000);
      end
      OpAdc: begin
        wide    = {1'b0, bus.a} + {1'b0, bus.b} + 17'(carry_q);
        res_d   = wide[15:0];
        carry_d = wide[16];
        ovf_d   = add_ovf(bus.a[15], bus.b[15], wide[15]);
      end
      OpSbb: begin
        wide    = {1'b0, bus.a} - {1'b0, bus.b} - 17'(carry_q);
        res_d   = wide[15:0];
        carry_d = wide[16];
        ovf_d   = sub_ovf(bus.a[15], bus.b[15], wide[15]);
      end
      default: begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outau_q <= '0;
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= bus.en;
      if (bus.en) begin
        outau_q <= res_d;
        carry_q <= carry_d;
        zero_q  <= (res_d == 16'h0000);
        neg_q   <= res_d[15];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign bus.outau     = outau_q;
  assign bus.out_valid = valid_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_arith_unit.sv
// Directed, table-driven bench for arith_unit: vector table plus hold and reset sequences.
module tb_arith_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arith_unit_if bus ();

  arith_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  // Packed view: {valid, carry, zero, neg, ovf, outau}
  function automatic logic [20:0] observed();
    return {bus.out_valid, bus.carry, bus.zero, bus.neg, bus.ovf, bus.outau};
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got vczno=%b outau=%h, want vczno=%b outau=%h",
               name, act[20:16], act[15:0], exp[20:16], exp[15:0]);
    end
  endtask

  task automatic add_vec(input string name, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res,
                         input logic c, input logic z, input logic n, input logic v);
    vec_t t;
    t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
    t.c = c; t.z = z; t.n = n; t.v = v;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    bus.en = en; bus.opcode = op; bus.a = a; bus.b = b;
    @(posedge clk);
    #1;
  endtask

  logic [20:0] held;

  initial begin
    checks = 0;
    errors = 0;
    bus.en = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0;

    //       name         op      a         b         res       c  z  n  v
    add_vec("add",       3'b000, 16'h0001, 16'h0010, 16'h0011, 0, 0, 0, 0);
    add_vec("sub_brw1",  3'b001, 16'h0001, 16'h0010, 16'hFFF1, 1, 0, 1, 0);
    add_vec("sub_brw2",  3'b001, 16'h0010, 16'h0011, 16'hFFFF, 1, 0, 1, 0);
    add_vec("inc",       3'b010, 16'h0001, 16'h1234, 16'h0002, 0, 0, 0, 0);
    add_vec("dec_zero",  3'b011, 16'h0001, 16'hFFFF, 16'h0000, 0, 1, 0, 0);
    add_vec("neg_one",   3'b101, 16'h0001, 16'h5555, 16'hFFFF, 1, 0, 1, 0);
    add_vec("neg_min",   3'b101, 16'h8000, 16'h0000, 16'h8000, 1, 0, 1, 1);
`ifdef ARITH_MUL_EN
    add_vec("mul_small", 3'b100, 16'h0010, 16'h0011, 16'h0110, 0, 0, 0, 0);
    add_vec("mul_wrap",  3'b100, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 1);
`else
    add_vec("mul_off1",  3'b100, 16'h0010, 16'h0011, 16'h0000, 0, 1, 0, 0);
    // Preceding NEG left carry=1; disabled MUL must clear it so ADC below adds 0.
    add_vec("neg_setc",  3'b101, 16'h0001, 16'h0000, 16'hFFFF, 1, 0, 1, 0);
    add_vec("mul_off2",  3'b100, 16'h0100, 16'h0100, 16'h0000, 0, 1, 0, 0);
    add_vec("adc_after", 3'b110, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0);
`endif
    add_vec("add_carry", 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0);
    add_vec("adc_chain", 3'b110, 16'h0000, 16'h0000, 16'h0001, 0, 0, 0, 0);
    add_vec("sub_0m1",   3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 1, 0);
    add_vec("sbb_chain", 3'b111, 16'h0005, 16'h0002, 16'h0002, 0, 0, 0, 0);
    add_vec("add_ovf",   3'b000, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 1);
    add_vec("inc_wrap",  3'b010, 16'hFFFF, 16'h0000, 16'h0000, 1, 1, 0, 0);
    add_vec("inc_ovf",   3'b010, 16'h7FFF, 16'h0000, 16'h8000, 0, 0, 1, 1);
    add_vec("dec_wrap",  3'b011, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 1, 0);
    add_vec("dec_ovf",   3'b011, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 0, 1);
    add_vec("sub_ovf",   3'b001, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
    add_vec("add_ffff2", 3'b000, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1, 0, 1, 0);
    add_vec("adc_ovf",   3'b110, 16'h7FFF, 16'h0000, 16'h8000, 0, 0, 1, 1);
    add_vec("sub_setb",  3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 1, 0);
    add_vec("sbb_brw",   3'b111, 16'h0000, 16'h0000, 16'hFFFF, 1, 0, 1, 0);
    add_vec("sbb_ovf",   3'b111, 16'h8000, 16'h0000, 16'h7FFF, 0, 0, 0, 1);

    // Reset state
    rst_n = 1'b0;
    #12;
    check("reset_state", observed(), 21'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", observed(), 21'h0);

    // Back-to-back vectors, en held high throughout
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, observed(),
            {1'b1, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v, vecs[i].res});
    end

    // Hold: en=0 for three cycles, inputs changing, outputs frozen and out_valid low
    held = {1'b0, observed()[19:0]};
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 3'b000, 16'h1111 * 16'(k + 1), 16'h2222);
      check($sformatf("hold_%0d", k), observed(), held);
    end

    // Stored carry survives the hold: last vector left carry=0, so ADC 1+1 = 2
    drive(1'b1, 3'b110, 16'h0001, 16'h0001);
    check("adc_after_hold", observed(), {5'b10000, 16'h0002});

    // Set carry=1, then assert reset mid-cycle with an operation pending
    drive(1'b1, 3'b000, 16'hFFFF, 16'h0001);
    check("add_setc", observed(), {5'b11100, 16'h0000});
    @(negedge clk);
    bus.en = 1'b1; bus.opcode = 3'b000; bus.a = 16'h1234; bus.b = 16'h0001;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", observed(), 21'h0);
    @(posedge clk);
    #1;
    check("reset_discard", observed(), 21'h0);
    @(negedge clk);
    bus.en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_idle", observed(), 21'h0);

    // Carry was cleared by reset: ADC 0+0 gives 0, not 1
    drive(1'b1, 3'b110, 16'h0000, 16'h0000);
    check("adc_after_reset", observed(), {5'b10100, 16'h0000});
    drive(1'b0, 3'b000, 16'h0000, 16'h0000);
    check("valid_drop", observed(), {5'b00100, 16'h0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
